// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_if
// Brief    : Request/grant and mux-control bundle of the shared-path arbiter.
// Revision : 1.0
// ============================================================================
interface mux_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
);
    logic [N_REQ-1:0] iReq;
    logic [N_REQ-1:0] oGnt;
    logic [SEL_W-1:0] oSel;
    logic             oEnb;
    logic             oBusy;

    modport master (
        input  iReq,
        output oGnt,
        output oSel,
        output oEnb,
        output oBusy
    );

    modport slave (
        output iReq,
        input  oGnt,
        input  oSel,
        input  oEnb,
        input  oBusy
    );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter
// Brief    : Round-robin owner of one shared mux path with break-before-make,
//            settle window and a per-ownership hold limit.
// Revision : 1.0
// ============================================================================
module mux_arbiter #(
    parameter int N_REQ      = 4,
    parameter int SEL_W      = 2,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_HOLD   = 8
) (
    input  wire              iClk,
    input  wire              iClr,
    mux_arbiter_if.master    bus
);
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [SCW-1:0]   c_SET_LAST = SCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [HW-1:0]    c_HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [SEL_W-1:0] c_IDX_LAST = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GRANT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [N_REQ-1:0] r_gnt;
    logic             r_enb;
    logic             r_busy;
    logic [SCW-1:0]   r_set_cnt;
    logic [HW-1:0]    r_hold;

    logic             w_found;
    logic [SEL_W-1:0] w_pick;

    function automatic logic [SEL_W-1:0] f_wrap(input logic [SEL_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return SEL_W'(s);
    endfunction

    // Scan downward so the candidate closest to r_ptr is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.iReq[f_wrap(r_ptr, k)] == 1'b1) begin
                w_found = 1'b1;
                w_pick  = f_wrap(r_ptr, k);
            end
        end
    end

    always_ff @(posedge iClk or negedge iClr) begin
        if (!iClr) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_gnt     <= '0;
            r_enb     <= 1'b1;
            r_busy    <= 1'b0;
            r_set_cnt <= '0;
            r_hold    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel  <= w_pick;
                        r_enb  <= 1'b0;
                        r_busy <= 1'b1;
                        if (SETTLE_CYC == 0) begin
                            r_gnt   <= N_REQ'(1) << w_pick;
                            r_hold  <= HW'(1);
                            r_state <= S_GRANT;
                        end else begin
                            r_set_cnt <= '0;
                            r_state   <= S_SETTLE;
                        end
                    end else begin
                        r_enb  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                // A requester that leaves during settle forfeits without moving r_ptr.
                S_SETTLE: begin
                    if (bus.iReq[r_sel] != 1'b1) begin
                        r_enb   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_set_cnt == c_SET_LAST) begin
                        r_gnt   <= N_REQ'(1) << r_sel;
                        r_hold  <= HW'(1);
                        r_state <= S_GRANT;
                    end else begin
                        r_set_cnt <= r_set_cnt + 1'b1;
                    end
                end
                S_GRANT: begin
                    if ((bus.iReq[r_sel] != 1'b1) ||
                        ((MAX_HOLD != 0) && (r_hold == c_HOLD_LIM))) begin
                        r_gnt   <= '0;
                        r_enb   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ptr   <= (r_sel == c_IDX_LAST) ? '0 : r_sel + 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_enb   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oGnt  = r_gnt;
    assign bus.oSel  = r_sel;
    assign bus.oEnb  = r_enb;
    assign bus.oBusy = r_busy;
endmodule
`default_nettype wire
